// File: rtl/raster_pkg.sv
// Shared pixel-stream types for the rasterizer and the pixel writer.
// pixel_t packs to 31 bits: [30:21]=x, [20:12]=y, [11:0]=RGB444.
package raster_pkg;

  typedef logic [11:0] rgb444_t;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    rgb444_t    color;
  } pixel_t;

  typedef enum logic {
    S_RUN,
    S_CLEAR
  } state_t;

  localparam int PIXEL_W = $bits(pixel_t);

endpackage

// File: rtl/raster_pixel_writer_if.sv
// Pixel stream handshake between rasterize (master) and the writer (slave).
// ready_out is high while the writer's input FIFO has room.
interface raster_pixel_writer_if;
  import raster_pkg::*;

  logic   valid_in;
  pixel_t pixel_in;
  logic   ready_out;

  modport master (
    output valid_in,
    output pixel_in,
    input  ready_out
  );

  modport slave (
    input  valid_in,
    input  pixel_in,
    output ready_out
  );

endinterface

// File: rtl/raster_pixel_writer_fifo.sv
// pixel_fifo: synchronous FIFO, DEPTH (power of two) x W bits.
// Head word is presented combinationally on o_data.
module pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 31
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [W-1:0]           i_data,
  output logic [W-1:0]           o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_wr;
  logic          w_rd;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_data  = r_mem[r_rd];
  assign w_wr    = i_push & ~o_full;
  assign w_rd    = i_pop & ~o_empty;

  // storage array, written on accepted push
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr] <= i_data;
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wr <= r_wr + 1'b1;
      if (w_rd) r_rd <= r_rd + 1'b1;
      unique case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/raster_pixel_writer.sv
// Pixel sink: FIFO -> stage1 -> stage2 (BRAM write), plus full-frame clear.
// Define BOUNDS_CHECK_EN to drop and count off-screen pixels.
module raster_pixel_writer
  import raster_pkg::*;
#(
  parameter int H_RES      = 320,
  parameter int V_RES      = 180,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_in,
  input  rgb444_t               clear_color_in,
  raster_pixel_writer_if.slave  pix,
  output logic                  busy_out,
  output logic                  overflow_out,
  output logic [ADDR_W-1:0]     fb_addr_out,
  output rgb444_t               fb_data_out,
  output logic                  fb_we_out,
  output logic [15:0]           dropped_cnt_out
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(H_RES * V_RES - 1);

  state_t            r_state;
  state_t            w_state_nx;
  logic              r_clr_pend;
  rgb444_t           r_clr_color;
  logic [ADDR_W-1:0] r_sweep;
  logic              r_ovf;
  logic              r_s1_v;
  pixel_t            r_s1;
  logic [ADDR_W-1:0] r_addr;
  rgb444_t           r_data;
  logic              r_we;

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  pixel_t            w_head;
  logic              w_inb;
  logic              w_sweep_done;
  logic [ADDR_W-1:0] w_addr;

  assign w_push = pix.valid_in & ~w_full;
  assign w_pop  = (r_state == S_RUN) & ~r_clr_pend
                & ~clear_in & ~w_empty;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PIXEL_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (pix.pixel_in),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign pix.ready_out = ~w_full;
  assign w_sweep_done  = (r_sweep == LAST_ADDR);
  assign w_addr = ADDR_W'(r_s1.y) * ADDR_W'(H_RES)
                + ADDR_W'(r_s1.x);

  assign busy_out = (r_state == S_CLEAR) | r_clr_pend
                  | (w_count != '0) | r_s1_v | r_we;
  assign overflow_out = r_ovf;
  assign fb_addr_out  = r_addr;
  assign fb_data_out  = r_data;
  assign fb_we_out    = r_we;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RUN;
    else        r_state <= w_state_nx;
  end

  // sweep starts once stage1 is empty; a restart keeps it in S_CLEAR
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_RUN:
        if (r_clr_pend && !r_s1_v) w_state_nx = S_CLEAR;
      S_CLEAR:
        if (!clear_in && w_sweep_done) w_state_nx = S_RUN;
      default: w_state_nx = S_RUN;
    endcase
  end

  // clear request, colour latch and sweep address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_pend  <= 1'b0;
      r_clr_color <= '0;
      r_sweep     <= '0;
    end else if (clear_in) begin
      r_clr_color <= clear_color_in;
      r_sweep     <= '0;
      if (r_state == S_RUN) r_clr_pend <= 1'b1;
    end else if (r_state == S_CLEAR) begin
      r_sweep <= r_sweep + 1'b1;
    end else if (w_state_nx == S_CLEAR) begin
      r_clr_pend <= 1'b0;
    end
  end

  // sticky overflow, released when a sweep completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else begin
      if (r_state == S_CLEAR && !clear_in && w_sweep_done)
        r_ovf <= 1'b0;
      if (pix.valid_in && w_full)
        r_ovf <= 1'b1;
    end
  end

  // stage1 pixel register and stage2 write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v <= 1'b0;
      r_s1   <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_we   <= 1'b0;
    end else begin
      r_s1_v <= w_pop;
      if (w_pop) r_s1 <= w_head;
      if (r_state == S_CLEAR) begin
        r_addr <= r_sweep;
        r_data <= r_clr_color;
        r_we   <= ~clear_in;
      end else begin
        r_addr <= w_addr;
        r_data <= r_s1.color;
        r_we   <= r_s1_v & w_inb;
      end
    end
  end

`ifdef BOUNDS_CHECK_EN
  logic [15:0] r_drop;

  assign w_inb = (int'(r_s1.x) < H_RES)
               && (int'(r_s1.y) < V_RES);
  assign dropped_cnt_out = r_drop;

  // saturating count of off-screen pixels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_drop <= '0;
    else if (clear_in)
      r_drop <= '0;
    else if (r_s1_v && !w_inb && r_drop != 16'hFFFF)
      r_drop <= r_drop + 1'b1;
  end
`else
  assign w_inb = 1'b1;
  assign dropped_cnt_out = 16'd0;
`endif

endmodule

// File: tb/tb_raster_pixel_writer.sv
// Self-checking bench for raster_pixel_writer.
// Honours BOUNDS_CHECK_EN when compiled with it.
module tb_raster_pixel_writer;
  import raster_pkg::*;

  localparam int H = 320;
  localparam int V = 180;
  localparam int NPIX = H * V;

  logic        clk;
  logic        rst_n;
  logic        clear_in;
  rgb444_t     clear_color_in;
  logic        busy_out;
  logic        overflow_out;
  logic [15:0] fb_addr_out;
  rgb444_t     fb_data_out;
  logic        fb_we_out;
  logic [15:0] dropped_cnt_out;

  raster_pixel_writer_if u_if ();

  raster_pixel_writer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .clear_in        (clear_in),
    .clear_color_in  (clear_color_in),
    .pix             (u_if),
    .busy_out        (busy_out),
    .overflow_out    (overflow_out),
    .fb_addr_out     (fb_addr_out),
    .fb_data_out     (fb_data_out),
    .fb_we_out       (fb_we_out),
    .dropped_cnt_out (dropped_cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int exp_drop = 0;
  logic [27:0] wq[$];
  logic [27:0] eq[$];

  always @(negedge clk)
    if (fb_we_out) wq.push_back({fb_addr_out, fb_data_out});

  typedef struct {
    int      x;
    int      y;
    rgb444_t c;
    int      addr;
    bit      we;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic pixel_t mkpix(input int x, input int y,
                                   input rgb444_t c);
    pixel_t p;
    p.x = 10'(x);
    p.y = 9'(y);
    p.color = c;
    return p;
  endfunction

  function automatic bit model_inb(input int x, input int y);
`ifdef BOUNDS_CHECK_EN
    return (x < H) && (y < V);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [27:0] model_wr(input int x, input int y,
                                           input rgb444_t c);
    int a;
    a = (y * H + x) % 65536;
    return {a[15:0], c};
  endfunction

  task automatic wait_idle(input string nm, input int maxc);
    int n;
    n = 0;
    while (busy_out && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {31'd0, busy_out}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int err;
    int n;
    int x;
    int y;
    rgb444_t c;
    bit hit;

    rst_n = 1'b0;
    clear_in = 1'b0;
    clear_color_in = '0;
    u_if.valid_in = 1'b0;
    u_if.pixel_in = '0;

    tbl[0] = '{10, 2, 12'hF00, 650, 1'b1};
    tbl[1] = '{0, 0, 12'h123, 0, 1'b1};
    tbl[2] = '{319, 179, 12'hABC, 57599, 1'b1};
    tbl[3] = '{0, 179, 12'h0C3, 57280, 1'b1};
    tbl[4] = '{319, 0, 12'h7E1, 319, 1'b1};
`ifdef BOUNDS_CHECK_EN
    tbl[5] = '{320, 0, 12'h0F0, 0, 1'b0};
    tbl[6] = '{0, 180, 12'h555, 0, 1'b0};
    tbl[7] = '{1023, 511, 12'hFFF, 0, 1'b0};
`else
    tbl[5] = '{320, 0, 12'h0F0, 320, 1'b1};
    tbl[6] = '{0, 180, 12'h555, 57600, 1'b1};
    tbl[7] = '{1023, 511, 12'hFFF, 33471, 1'b1};
`endif

    #1;
    chk("rst_ready", {31'd0, u_if.ready_out}, 1);
    chk("rst_busy", {31'd0, busy_out}, 0);
    chk("rst_we", {31'd0, fb_we_out}, 0);
    chk("rst_ovf", {31'd0, overflow_out}, 0);
    chk("rst_addr", {16'd0, fb_addr_out}, 0);
    chk("rst_data", {20'd0, fb_data_out}, 0);
    chk("rst_drop", {16'd0, dropped_cnt_out}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // table: single pixels, latency and address
    for (int i = 0; i < 8; i++) begin
      u_if.valid_in = 1'b1;
      u_if.pixel_in = mkpix(tbl[i].x, tbl[i].y, tbl[i].c);
      chk($sformatf("t%0d_ready", i), {31'd0, u_if.ready_out}, 1);
      @(negedge clk);
      u_if.valid_in = 1'b0;
      chk($sformatf("t%0d_we_n0", i), {31'd0, fb_we_out}, 0);
      @(negedge clk);
      chk($sformatf("t%0d_we_n1", i), {31'd0, fb_we_out}, 0);
      @(negedge clk);
      chk($sformatf("t%0d_we_n2", i), {31'd0, fb_we_out},
          {31'd0, tbl[i].we});
      if (tbl[i].we) begin
        chk($sformatf("t%0d_addr", i), {16'd0, fb_addr_out},
            tbl[i].addr);
        chk($sformatf("t%0d_data", i), {20'd0, fb_data_out},
            {20'd0, tbl[i].c});
      end
`ifdef BOUNDS_CHECK_EN
      if (!tbl[i].we) exp_drop++;
`endif
      chk($sformatf("t%0d_drop", i), {16'd0, dropped_cnt_out},
          exp_drop);
      @(negedge clk);
      chk($sformatf("t%0d_once", i), {31'd0, fb_we_out}, 0);
    end

    // random stream against the address/bounds model
    wq.delete();
    eq.delete();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 7) == 0) begin
          x = $urandom_range(0, 1023);
          y = $urandom_range(V, 511);
        end else begin
          x = $urandom_range(0, H - 1);
          y = $urandom_range(0, V - 1);
        end
        c = 12'($urandom);
        u_if.valid_in = 1'b1;
        u_if.pixel_in = mkpix(x, y, c);
        if (u_if.ready_out) begin
          if (model_inb(x, y)) eq.push_back(model_wr(x, y, c));
          else exp_drop++;
        end
      end else begin
        u_if.valid_in = 1'b0;
      end
      @(negedge clk);
    end
    u_if.valid_in = 1'b0;
    wait_idle("rnd_idle", 100);
    chk("rnd_len", wq.size(), eq.size());
    err = 0;
    for (int i = 0; i < wq.size() && i < eq.size(); i++)
      if (wq[i] !== eq[i]) err++;
    chk("rnd_content", err, 0);
    chk("rnd_drop", {16'd0, dropped_cnt_out}, exp_drop);
    chk("rnd_ovf", {31'd0, overflow_out}, 0);

    // clear with simultaneous pixel, then overflow the held FIFO
    wq.delete();
    eq.delete();
    clear_in = 1'b1;
    clear_color_in = 12'h00F;
    u_if.valid_in = 1'b1;
    u_if.pixel_in = mkpix(5, 5, 12'h0F0);
    eq.push_back(model_wr(5, 5, 12'h0F0));
    @(negedge clk);
    clear_in = 1'b0;
    chk("clr_busy", {31'd0, busy_out}, 1);
    for (int i = 1; i < 17; i++) begin
      x = $urandom_range(0, H - 1);
      y = $urandom_range(0, V - 1);
      c = 12'($urandom);
      u_if.pixel_in = mkpix(x, y, c);
      if (i < 16) eq.push_back(model_wr(x, y, c));
      if (i == 16)
        chk("ovf_ready0", {31'd0, u_if.ready_out}, 0);
      @(negedge clk);
    end
    u_if.valid_in = 1'b0;
    chk("ovf_set", {31'd0, overflow_out}, 1);
    chk("ovf_busy", {31'd0, busy_out}, 1);
    wait_idle("sweep_idle", 70000);
    chk("sweep_len", wq.size(), NPIX + 16);
    err = 0;
    for (int i = 0; i < NPIX && i < wq.size(); i++)
      if (wq[i] !== {16'(i), 12'h00F}) err++;
    chk("sweep_content", err, 0);
    err = 0;
    for (int k = 0; k < 16 && NPIX + k < wq.size(); k++)
      if (wq[NPIX + k] !== eq[k]) err++;
    chk("post_sweep_pix", err, 0);
    if (wq.size() > NPIX)
      chk("first_after_sweep", {4'd0, wq[NPIX]},
          {4'd0, 16'd1605, 12'h0F0});
    chk("ovf_cleared", {31'd0, overflow_out}, 0);
    chk("drop_cleared", {16'd0, dropped_cnt_out}, 0);
    chk("idle_ready", {31'd0, u_if.ready_out}, 1);

    // reset in the middle of a sweep
    wq.delete();
    clear_in = 1'b1;
    clear_color_in = 12'hA5A;
    @(negedge clk);
    clear_in = 1'b0;
    n = 0;
    hit = 1'b0;
    while (n < 2000 && !hit) begin
      @(negedge clk);
      n++;
      hit = fb_we_out && fb_addr_out == 16'd1000;
    end
    chk("reach_1000", {31'd0, hit}, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", {31'd0, fb_we_out}, 0);
    chk("mid_rst_ready", {31'd0, u_if.ready_out}, 1);
    chk("mid_rst_busy", {31'd0, busy_out}, 0);
    chk("mid_rst_addr", {16'd0, fb_addr_out}, 0);
    chk("mid_rst_data", {20'd0, fb_data_out}, 0);
    chk("pre_rst_writes", wq.size(), 1001);
    repeat (5) @(negedge clk);
    chk("no_wr_in_rst", wq.size(), 1001);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("after_rst_we", {31'd0, fb_we_out}, 0);
    chk("after_rst_busy", {31'd0, busy_out}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
